iq_serializer: RTL

//  Transmit-side counterpart of the IQ capture buffer: accepts packed {I,Q} 24-bit pairs and

---
 rtl/iq_pkg.sv | 10 +
 rtl/iq_pair_fifo.sv | 43 ++++
 rtl/iq_serializer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/iq_pkg.sv
// iq_pkg: shared IQ sample width, I/Q phase encoding and packed {I,Q} pair type.
// Used by both the capture buffer and iq_serializer.
package iq_pkg;
    localparam int IQ_DATA_W = 12;
    typedef enum logic {PH_I = 1'b0, PH_Q = 1'b1} iq_phase_e;
    typedef struct packed {
        logic [IQ_DATA_W-1:0] i;
        logic [IQ_DATA_W-1:0] q;
    } iq_pair_t;
endpackage

// File: rtl/iq_pair_fifo.sv
// iq_pair_fifo: synchronous first-word-fall-through FIFO of packed {I,Q} pairs.
// Pointers carry an extra MSB so full and empty are distinguishable.
module iq_pair_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sclr,
    input  logic                     wr,
    input  logic [W-1:0]             wdata,
    input  logic                     rd,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, rptr_q;
    logic         push, pop;
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = wptr_q == rptr_q;
    assign count = wptr_q - rptr_q;
    assign rdata = mem_q[rptr_q[AW-1:0]];
    assign push  = wr & ~full;
    assign pop   = rd & ~empty;
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (sclr) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
        end
    end
endmodule

// File: rtl/iq_serializer.sv
// iq_serializer: replays packed {I,Q} pairs as an interleaved I-then-Q sample stream.
// Define IQSER_ZERO_FILL_EN to emit zero samples on underflow and keep I/Q alignment.
module iq_serializer import iq_pkg::*; #(
    parameter int DATA_W = IQ_DATA_W,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sclr,
    input  logic [2*DATA_W-1:0]      din,
    input  logic                     writerq,
    input  logic                     readrq,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_valid,
    output logic                     iq_sel,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int LW = $clog2(DEPTH) + 1;
    logic [2*DATA_W-1:0] fifo_rdata, hold_q;
    logic                fifo_full, fifo_empty, hold_v_q, take, pop, fill;
    logic [LW-1:0]       fifo_cnt;
    logic [DATA_W-1:0]   dout_q;
    logic                dout_valid_q, iq_sel_q, ovf_q, unf_q;
    iq_phase_e           phase_q;
`ifdef IQSER_ZERO_FILL_EN
    logic                zf_q;
    assign fill = zf_q;
`else
    assign fill = 1'b0;
`endif
    iq_pair_fifo #(.W(2*DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .sclr  (sclr),
        .wr    (writerq),
        .wdata (din),
        .rd    (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );
    // Q of a real pair retires the holding reg; the FIFO head refills it on the same edge.
    assign take = (phase_q == PH_Q) & readrq & hold_v_q & ~fill;
    assign pop  = ~fifo_empty & (~hold_v_q | take);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q       <= '0;
            hold_v_q     <= 1'b0;
            phase_q      <= PH_I;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            iq_sel_q     <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
`ifdef IQSER_ZERO_FILL_EN
            zf_q         <= 1'b0;
`endif
        end else if (sclr) begin
            hold_q       <= '0;
            hold_v_q     <= 1'b0;
            phase_q      <= PH_I;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            iq_sel_q     <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
`ifdef IQSER_ZERO_FILL_EN
            zf_q         <= 1'b0;
`endif
        end else begin
            dout_valid_q <= 1'b0;
            if (writerq & fifo_full) ovf_q <= 1'b1;
            if (pop) begin
                hold_q   <= fifo_rdata;
                hold_v_q <= 1'b1;
            end else if (take) begin
                hold_v_q <= 1'b0;
            end
            if (readrq) begin
                if (phase_q == PH_I) begin
                    if (hold_v_q) begin
                        dout_q       <= hold_q[2*DATA_W-1:DATA_W];
                        iq_sel_q     <= 1'b0;
                        dout_valid_q <= 1'b1;
                        phase_q      <= PH_Q;
                    end else begin
                        unf_q        <= 1'b1;
`ifdef IQSER_ZERO_FILL_EN
                        dout_q       <= '0;
                        iq_sel_q     <= 1'b0;
                        dout_valid_q <= 1'b1;
                        phase_q      <= PH_Q;
                        zf_q         <= 1'b1;
`endif
                    end
                end else begin
                    dout_q       <= fill ? '0 : hold_q[DATA_W-1:0];
                    iq_sel_q     <= 1'b1;
                    dout_valid_q <= 1'b1;
                    phase_q      <= PH_I;
`ifdef IQSER_ZERO_FILL_EN
                    zf_q         <= 1'b0;
`endif
                end
            end
        end
    end
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign iq_sel     = iq_sel_q;
    assign full       = fifo_full;
    assign empty      = fifo_empty & ~hold_v_q;
    assign level      = fifo_cnt + {{(LW-1){1'b0}}, hold_v_q};
    assign overflow   = ovf_q;
    assign underflow  = unf_q;
endmodule
